// File: rtl/vram_pkg.sv
// Shared types and constants for the dual-port video RAM.
package vram_pkg;

    typedef enum logic {ST_CLEAR, ST_RUN} vram_state_t;

    typedef enum logic [1:0] {SC_IDLE, SC_RUN, SC_DONE} scan_state_t;

    localparam int unsigned STREAM_DEPTH = 2;

endpackage

// File: rtl/vram_dp_if.sv
// CPU port and display stream port of vram_dp grouped as one bundle.
interface vram_dp_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 16
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              busy;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [BE_W-1:0]   cpu_be;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              disp_start;
    logic [ADDR_W-1:0] disp_base;
    logic [LEN_W-1:0]  disp_len;
    logic              disp_active;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              disp_ready;
    logic              disp_done;

    modport slave (
        output busy,
        input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_rvalid,
        input  disp_start, disp_base, disp_len,
        output disp_active, disp_data, disp_valid,
        input  disp_ready,
        output disp_done
    );

    modport master (
        input  busy,
        output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_rvalid,
        output disp_start, disp_base, disp_len,
        input  disp_active, disp_data, disp_valid,
        output disp_ready,
        input  disp_done
    );

endinterface

// File: rtl/vram_scanout.sv
// Scanout engine: linear wrapping address generator, one-deep read pipeline tracking and a
// two-entry stream buffer feeding a valid/ready sink.
module vram_scanout
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start_en,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_active,
    output logic              o_done,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data
);
    localparam int unsigned PTR_W = $clog2(STREAM_DEPTH);
    localparam int unsigned CNT_W = $clog2(STREAM_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    scan_state_t       r_state, w_state_d;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remain;
    logic              r_inflight;
    logic [DATA_W-1:0] r_buf [STREAM_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_start, w_pop, w_issue, w_last;
    logic [SUM_W-1:0]  w_pending;

    assign w_start   = i_start && i_start_en && (r_state != SC_RUN);
    assign w_pop     = (r_count != '0) && i_ready;
    // A slot freed by this cycle's pop may be claimed by this cycle's read.
    assign w_pending = {1'b0, r_count} + SUM_W'(r_inflight);
    assign w_issue   = (r_state == SC_RUN) && (r_remain != '0) &&
                       (w_pending < SUM_W'(STREAM_DEPTH) + SUM_W'(w_pop));
    assign w_last    = (r_state == SC_RUN) && (r_remain == '0) && !r_inflight &&
                       ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SC_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            SC_IDLE, SC_DONE: begin
                w_state_d = SC_IDLE;
                if (w_start) begin
                    w_state_d = (i_len == '0) ? SC_DONE : SC_RUN;
                end
            end
            SC_RUN: begin
                if (w_last) begin
                    w_state_d = SC_DONE;
                end
            end
            default: w_state_d = SC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < STREAM_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= w_issue;
            if (w_start) begin
                r_addr   <= i_base;
                r_remain <= i_len;
            end else if (w_issue) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_remain <= r_remain - LEN_W'(1);
            end
            if (r_inflight) begin
                r_buf[r_wr_ptr] <= i_rd_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
        end
    end

    assign o_active  = (r_state == SC_RUN);
    assign o_done    = (r_state == SC_DONE);
    assign o_valid   = (r_count != '0);
    assign o_data    = r_buf[r_rd_ptr];
    assign o_rd_en   = w_issue;
    assign o_rd_addr = r_addr;

endmodule

// File: rtl/vram_dp.sv
// Dual-port video RAM: byte-enabled CPU port, scanout stream port, one-word-per-cycle clear.
// Define VRAM_TEST_PATTERN_EN to clear each byte to the low address byte instead of zero.
module vram_dp
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 16
) (
    input logic       clk,
    input logic       rst,
    vram_dp_if.slave  bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    vram_state_t       r_state, w_state_d;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_fill;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_cpu_rvalid;
    logic [DATA_W-1:0] r_b_rdata;
    logic              w_run, w_cpu_wr, w_cpu_rd;
    logic              w_b_rd_en;
    logic [ADDR_W-1:0] w_b_rd_addr;

`ifdef VRAM_TEST_PATTERN_EN
    logic [7:0] w_cnt_byte;
    assign w_cnt_byte = 8'(r_clr_cnt);
    assign w_fill     = {BE_W{w_cnt_byte}};
`else
    assign w_fill = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == {ADDR_W{1'b1}}) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN:  w_state_d = ST_RUN;
            default: w_state_d = ST_CLEAR;
        endcase
    end

    assign w_run    = (r_state == ST_RUN);
    assign w_cpu_wr = w_run && bus.cpu_req && bus.cpu_we;
    assign w_cpu_rd = w_run && bus.cpu_req && !bus.cpu_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_cnt] <= w_fill;
            end else if (w_cpu_wr) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (bus.cpu_be[i]) begin
                        r_mem[bus.cpu_addr][8*i +: 8] <= bus.cpu_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Scanout read samples the array before this cycle's CPU write lands (read-first).
    always_ff @(posedge clk) begin
        if (w_b_rd_en) begin
            r_b_rdata <= r_mem[w_b_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_rd;
            if (w_cpu_rd) begin
                r_cpu_rdata <= r_mem[bus.cpu_addr];
            end
        end
    end

    assign bus.busy       = (r_state == ST_CLEAR);
    assign bus.cpu_ready  = w_run;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.cpu_rvalid = r_cpu_rvalid;

    vram_scanout #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_scanout (
        .clk        (clk),
        .rst        (rst),
        .i_start_en (w_run),
        .i_start    (bus.disp_start),
        .i_base     (bus.disp_base),
        .i_len      (bus.disp_len),
        .o_active   (bus.disp_active),
        .o_done     (bus.disp_done),
        .o_data     (bus.disp_data),
        .o_valid    (bus.disp_valid),
        .i_ready    (bus.disp_ready),
        .o_rd_en    (w_b_rd_en),
        .o_rd_addr  (w_b_rd_addr),
        .i_rd_data  (r_b_rdata)
    );

endmodule

// File: tb/tb_vram_dp.sv
// Bench for vram_dp: directed and random CPU/scanout traffic against a word-array model,
// checked by a negedge monitor that pops expected responses from scoreboard queues.
module tb_vram_dp;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 16;
    localparam int          WORDS  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vram_dp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    vram_dp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          rdy_mode = 0;
    int          rdy_phase = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [15:0] model [WORDS];
    logic [15:0] cpu_exp[$];
    logic [15:0] disp_exp[$];
    int          hs_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < WORDS; i++) begin
`ifdef VRAM_TEST_PATTERN_EN
            model[i] = {2{8'(i)}};
`else
            model[i] = '0;
`endif
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Sink readiness: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
    always @(posedge clk) begin
        #1;
        rdy_phase = rdy_phase + 1;
        case (rdy_mode)
            0:       bus.disp_ready = 1'b1;
            1:       bus.disp_ready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
            default: bus.disp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (bus.cpu_rvalid) begin
            if (cpu_exp.size() == 0) chk("cpu_rvalid with no read pending", 32'(bus.cpu_rvalid), 0);
            else chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_exp.pop_front()));
        end
        if (bus.disp_valid) begin
            if (prev_stall) chk("disp_data stable while stalled", 32'(bus.disp_data),
                                32'(prev_data));
            if (bus.disp_ready) begin
                if (disp_exp.size() == 0) chk("disp word with none pending", 32'(bus.disp_valid), 0);
                else chk("disp_data", 32'(bus.disp_data), 32'(disp_exp.pop_front()));
                hs_cyc.push_back(cyc);
            end
            prev_stall = !bus.disp_ready;
            prev_data  = bus.disp_data;
        end else begin
            if (prev_stall) chk("disp_valid held while stalled", 32'(bus.disp_valid), 1);
            prev_stall = 1'b0;
        end
        if (bus.disp_done) done_cnt++;
    end

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        prev_stall = 1'b0;
        disp_exp.delete();
        chk("reset busy",        32'(bus.busy),        1);
        chk("reset cpu_ready",   32'(bus.cpu_ready),   0);
        chk("reset cpu_rvalid",  32'(bus.cpu_rvalid),  0);
        chk("reset cpu_rdata",   32'(bus.cpu_rdata),   0);
        chk("reset disp_active", 32'(bus.disp_active), 0);
        chk("reset disp_valid",  32'(bus.disp_valid),  0);
        chk("reset disp_data",   32'(bus.disp_data),   0);
        chk("reset disp_done",   32'(bus.disp_done),   0);
    endtask

    task automatic wait_clear();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("clear length in cycles", n, 16);
        chk("cpu_ready with busy low", 32'(bus.cpu_ready), 1);
        model_clear();
    endtask

    task automatic cpu_op(input logic we, input int addr, input logic [1:0] be,
                          input logic [15:0] wd);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = ADDR_W'(addr);
        bus.cpu_be    = be;
        bus.cpu_wdata = wd;
        if (!we) begin
            cpu_exp.push_back(model[addr]);
        end else begin
            if (be[0]) model[addr][7:0]  = wd[7:0];
            if (be[1]) model[addr][15:8] = wd[15:8];
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic scan_start(input int base, input int len);
        for (int i = 0; i < len; i++) disp_exp.push_back(model[(base + i) % WORDS]);
        bus.disp_start = 1'b1;
        bus.disp_base  = ADDR_W'(base);
        bus.disp_len   = LEN_W'(len);
        @(posedge clk); #1;
        bus.disp_start = 1'b0;
    endtask

    task automatic scan_wait();
        int n = 0;
        while (!bus.disp_done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scan done within bound", 32'(bus.disp_done), 1);
        chk("disp_active low with done", 32'(bus.disp_active), 0);
        chk("stream fully delivered", disp_exp.size(), 0);
    endtask

    initial begin
        int k;
        int d0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_be = '0;
        bus.cpu_wdata = '0; bus.disp_start = 1'b0; bus.disp_base = '0; bus.disp_len = '0;
        bus.disp_ready = 1'b1;
        @(posedge clk); #1;

        pulse_rst();
        wait_clear();
        for (int a = 0; a < WORDS; a++) cpu_op(1'b0, a, 2'b00, 16'h0);

        // Byte-enable merge, read visible one cycle after the request.
        cpu_op(1'b1, 5, 2'b11, 16'hABCD);
        cpu_op(1'b1, 5, 2'b10, 16'h1200);
        cpu_op(1'b0, 5, 2'b00, 16'h0);
        chk("be read rvalid", 32'(bus.cpu_rvalid), 1);
        chk("be read merged data", 32'(bus.cpu_rdata), 32'h12CD);

        // Wrapping scanout with the sink always ready.
        for (int a = 0; a < WORDS; a++) cpu_op(1'b1, a, 2'b11, 16'(a));
        rdy_mode = 0;
        hs_cyc.delete();
        scan_start(14, 4);
        k = 0;
        while (!bus.disp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("first disp_valid edges after start", k, 2);
        scan_wait();
        chk("wrap word count", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4) begin
            chk("wrap words on consecutive cycles", hs_cyc[3] - hs_cyc[0], 3);
            chk("done one cycle after last word", cyc - hs_cyc[3], 1);
        end
        @(posedge clk); #1;
        chk("disp_done is a single pulse", 32'(bus.disp_done), 0);

        // Backpressure, plus a start pulse that must be ignored mid-scan.
        rdy_mode = 1;
        scan_start(14, 4);
        repeat (3) begin @(posedge clk); #1; end
        chk("active during stalled scan", 32'(bus.disp_active), 1);
        bus.disp_start = 1'b1; bus.disp_base = '0; bus.disp_len = LEN_W'(3);
        @(posedge clk); #1;
        bus.disp_start = 1'b0;
        scan_wait();

        // Zero-length scan.
        rdy_mode = 0;
        scan_start(7, 0);
        chk("len0 done next cycle", 32'(bus.disp_done), 1);
        chk("len0 no valid", 32'(bus.disp_valid), 0);
        @(posedge clk); #1;

        // Read-first collision between scanout and CPU write.
        scan_start(2, 1);
        cpu_op(1'b1, 2, 2'b11, 16'hFFFF);
        scan_wait();
        cpu_op(1'b0, 2, 2'b00, 16'h0);

        // Random CPU traffic, then random scans with concurrent reads.
        repeat (300) begin
            cpu_op(1'($urandom_range(0, 1)), $urandom_range(0, WORDS - 1),
                   2'($urandom_range(0, 3)), 16'($urandom));
        end
        rdy_mode = 2;
        repeat (8) begin
            scan_start($urandom_range(0, WORDS - 1), $urandom_range(0, 12));
            k = 0;
            while (!bus.disp_done && k < 300) begin
                cpu_op(1'b0, $urandom_range(0, WORDS - 1), 2'b00, 16'h0);
                k++;
            end
            chk("random scan done", 32'(bus.disp_done), 1);
            chk("random scan drained", disp_exp.size(), 0);
        end

        // Reset at clear counter 7 restarts the full clear.
        pulse_rst();
        repeat (7) begin @(posedge clk); #1; end
        chk("busy mid-clear", 32'(bus.busy), 1);
        pulse_rst();
        wait_clear();
        for (int a = 0; a < WORDS; a++) cpu_op(1'b0, a, 2'b00, 16'h0);

        // Reset mid-scanout drops the stream without a done pulse.
        for (int a = 0; a < WORDS; a++) cpu_op(1'b1, a, 2'b11, 16'($urandom));
        rdy_mode = 1;
        d0 = done_cnt;
        scan_start(3, 10);
        repeat (5) begin @(posedge clk); #1; end
        pulse_rst();
        wait_clear();
        chk("no done after aborted scan", done_cnt, d0);
        rdy_mode = 0;
        scan_start(0, 3);
        scan_wait();

        repeat (3) begin @(posedge clk); #1; end
        chk("cpu reads all answered", cpu_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vram_dp.md
# vram_dp

Dual-port, parametrised video RAM, the successor to the single-port byte VRAM. It serves a CPU read/write port with byte enables and an internal scanout engine. The scanout engine streams a linear address range to the display pipeline over a valid/ready interface with backpressure. A reset-driven clear sequencer initialises memory one word per cycle instead of in a single cycle.

## Interface
- `ADDR_W`, 20, word-address width; depth = 2**`ADDR_W` words
- `DATA_W`, 8, word width; must be a multiple of 8; `BE_W` = `DATA_W`/8
- `LEN_W`, 16, width of scanout length field
- `clk` in 1, clock
- `rst` in 1, reset, synchronous, active-high
- `busy` out 1, high while the clear sequence runs
- `cpu_req` in 1, CPU access request
- `cpu_we` in 1, 1 = write, 0 = read
- `cpu_addr` in `ADDR_W`, CPU word address
- `cpu_be` in `BE_W`, byte enables for writes
- `cpu_wdata` in `DATA_W`, write data
- `cpu_ready` out 1, request accepted this cycle
- `cpu_rdata` out `DATA_W`, read data
- `cpu_rvalid` out 1, `cpu_rdata` valid pulse
- `disp_start` in 1, single-cycle scanout start pulse
- `disp_base` in `ADDR_W`, first scanout address
- `disp_len` in `LEN_W`, number of words to stream
- `disp_active` out 1, scanout in progress
- `disp_data` out `DATA_W`, stream data
- `disp_valid` out 1, stream data valid
- `disp_ready` in 1, display sink accepts
- `disp_done` out 1, one-cycle pulse when the scanout completes

## Operation
- **Top FSM states:** `CLEAR` and `RUN`.
  - `rst` forces `CLEAR`, sets the clear counter to 0, aborts any scanout and flushes the stream buffer.
- **`CLEAR`:**
  - Each cycle writes the fill word to `mem[counter]` and increments the counter.
  - After writing address 2**`ADDR_W`-1, the FSM moves to `RUN`.
  - In `CLEAR`: `busy`=1, `cpu_ready`=0, and `disp_start` is ignored.
  - Fill word is 0 unless `VRAM_TEST_PATTERN_EN` is defined.
- **`RUN`:**
  - `cpu_ready`=1 every cycle.
  - A write updates only the bytes with `cpu_be`[i]=1.
  - A read returns `mem[cpu_addr]` with `cpu_rvalid` pulsed one cycle later.
  - Writes do not update `cpu_rdata` and do not pulse `cpu_rvalid`.
- **Port B (scanout):**
  - `disp_start` in `RUN` with `disp_active`=0 latches base and length and sets `disp_active`.
  - `disp_start` is ignored while `disp_active`=1.
  - The engine reads address (`disp_base`+i) mod 2**`ADDR_W` for i = 0..`disp_len`-1. Addresses wrap past the top.
  - Reads enter a 2-entry output buffer.
  - A read issues only when occupancy + in-flight − (`disp_valid` & `disp_ready`) < 2. No data is ever dropped.
  - The stream is in order; `disp_data` holds stable while `disp_valid`=1 and `disp_ready`=0.
  - `disp_done` pulses in the cycle after the final word is accepted; `disp_active` falls in that same cycle.
  - `disp_len`=0: no words are streamed; `disp_done` pulses the cycle after `disp_start`.
- **Collision:** CPU write and scanout read to the same address in the same cycle → scanout gets the old data (read-first).

## Timing
- Reset values:
  - `busy`=1 from the cycle after `rst`.
  - `cpu_ready`=0, `cpu_rvalid`=0, `cpu_rdata`=0.
  - `disp_active`=0, `disp_valid`=0, `disp_data`=0, `disp_done`=0.
- Clear lasts exactly 2**`ADDR_W` cycles after `rst` deasserts. `busy` falls and `cpu_ready` rises in the same cycle.
- CPU read latency is 1 cycle: request at edge t, data and `cpu_rvalid` registered at edge t+1.
- Read-after-write to the same address on the next cycle returns the new data.
- Scanout:
  - First `disp_valid` appears 2 cycles after `disp_start`.
  - With `disp_ready` held high, the stream sustains 1 word per cycle.
- `rst` mid-clear restarts the clear at address 0. `rst` mid-scanout drops the stream without pulsing `disp_done`.
- All logic is on `posedge clk`; there is no negedge logic.

## Configuration
- `VRAM_TEST_PATTERN_EN` defined: the clear writes fill word = address replicated per byte, i.e. each byte = `counter`[7:0].
- Not defined: the clear writes all-zero words.
- The macro affects nothing else; no initial blocks in either build.

## Structure
- Package `vram_pkg`:
  - `vram_state_t` enum {`ST_CLEAR`, `ST_RUN`}.
  - `scan_state_t` enum {`SC_IDLE`, `SC_RUN`, `SC_DONE`}.
  - Constant `STREAM_DEPTH`=2.
- Sub-module `vram_scanout`:
  - Contains the address generator, the in-flight tracking and the 2-entry stream buffer.
  - Talks to the memory array through a read-address/read-enable pair.
  - The top owns the memory array, the clear FSM and the CPU port.

## Test plan
- Run all scenarios with `ADDR_W`=4, `DATA_W`=16.
- **Clear:** `rst` 1 cycle → `busy` high exactly 16 cycles; reads of addresses 0..15 return 0x0000, or 0x0303 at addr 3 with `VRAM_TEST_PATTERN_EN`.
- **Byte enables:** write 0xABCD to addr 5 with be=2'b11, then 0x1200 with be=2'b10; read addr 5 → 0x12CD one cycle after the request.
- **Scanout wrap:** memory holds word = addr; `disp_base`=14, `disp_len`=4, `disp_ready`=1 → stream 14, 15, 0, 1 on consecutive cycles, then `disp_done` pulse.
- **Backpressure:** same scanout with `disp_ready` toggled 1,0,0,1,… → no loss or duplication; `disp_data` stable while stalled.
- **Collision:** CPU writes 0xFFFF to addr 2 in the same cycle the scanout reads addr 2 (old value 0x0002) → stream carries 0x0002; a later CPU read returns 0xFFFF.
- **Reset mid-operation:** `rst` at clear counter 7, and separately mid-scanout → clear restarts at 0 and runs the full 16 cycles; `disp_valid` and `disp_active` go to 0 with no `disp_done`.
